// File: rtl/writeback_rr_l2_pkg.sv
// Shared constants for the round-robin writeback stage.
// The writeback entry struct depends on p_seq_num_bits, so it is declared inside the top.
package WbPkg;

  localparam int WB_PC_BITS   = 32;
  localparam int WB_DATA_BITS = 32;
  localparam int WB_ADDR_BITS = 5;

  localparam logic [WB_ADDR_BITS-1:0] WB_ZERO_REG = 5'd0;

endpackage

// File: rtl/writeback_rr_l2_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping modulo p_num_pipes.
// ptr moves to one past the winner whenever a transfer happens.
module rr_arbiter #(
  parameter int p_num_pipes = 3,
  localparam int IDX_W = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [p_num_pipes-1:0] req,
  input  logic                   xfer,
  output logic [p_num_pipes-1:0] grant,
  output logic [IDX_W-1:0]       grant_idx
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic             found;
  int               cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int off = 0; off < p_num_pipes; off++) begin
      cand = int'(ptr_q) + off;
      if (cand >= p_num_pipes) begin
        cand = cand - p_num_pipes;
      end
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      if (grant_idx == IDX_W'(p_num_pipes - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/writeback_rr_l2.sv
// Writeback stage: round-robin picks one execute-pipe transfer per cycle, registers it,
// then drives the register-file write port, a commit notification and a retire counter.
module writeback_rr_l2
  import WbPkg::*;
#(
  parameter int p_num_pipes    = 3,
  parameter int p_seq_num_bits = 5,
  localparam int IDX_W = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [p_num_pipes-1:0]                       X_val,
  output logic [p_num_pipes-1:0]                       X_rdy,
  input  logic [p_num_pipes-1:0][WB_PC_BITS-1:0]       X_pc,
  input  logic [p_num_pipes-1:0][p_seq_num_bits-1:0]   X_seq_num,
  input  logic [p_num_pipes-1:0][WB_ADDR_BITS-1:0]     X_waddr,
  input  logic [p_num_pipes-1:0][WB_DATA_BITS-1:0]     X_wdata,
  input  logic [p_num_pipes-1:0]                       X_wen,
  output logic                                         rf_wen,
  output logic [WB_ADDR_BITS-1:0]                      rf_waddr,
  output logic [WB_DATA_BITS-1:0]                      rf_wdata,
  output logic                                         commit_val,
  output logic [WB_PC_BITS-1:0]                        commit_pc,
  output logic [p_seq_num_bits-1:0]                    commit_seq_num,
  output logic [31:0]                                  retire_count
);

  typedef struct packed {
    logic                      val;
    logic [WB_PC_BITS-1:0]     pc;
    logic [p_seq_num_bits-1:0] seq_num;
    logic [WB_ADDR_BITS-1:0]   waddr;
    logic [WB_DATA_BITS-1:0]   wdata;
    logic                      wen;
  } wb_entry_t;

  wb_entry_t        wb_q;
  wb_entry_t        wb_d;
  logic [31:0]      retire_q;
  logic [31:0]      retire_d;
  logic [IDX_W-1:0] grant_idx;
  logic             xfer;

  assign xfer = |(X_val & X_rdy);

  rr_arbiter #(
    .p_num_pipes (p_num_pipes)
  ) u_arbiter (
    .clk       (clk),
    .rst       (rst),
    .req       (X_val),
    .xfer      (xfer),
    .grant     (X_rdy),
    .grant_idx (grant_idx)
  );

  // Payload is left stale when idle; the output masking hides it.
  always_comb begin
    wb_d     = wb_q;
    wb_d.val = 1'b0;
    if (xfer) begin
      wb_d.val     = 1'b1;
      wb_d.pc      = X_pc[grant_idx];
      wb_d.seq_num = X_seq_num[grant_idx];
      wb_d.waddr   = X_waddr[grant_idx];
      wb_d.wdata   = X_wdata[grant_idx];
      wb_d.wen     = X_wen[grant_idx];
    end
  end

  always_comb begin
    retire_d = retire_q;
    if (wb_q.val) begin
      retire_d = retire_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q     <= '0;
      retire_q <= '0;
    end else begin
      wb_q     <= wb_d;
      retire_q <= retire_d;
    end
  end

  // x0 writes still commit but never reach the register file.
  assign commit_val     = wb_q.val;
  assign commit_pc      = wb_q.val ? wb_q.pc : '0;
  assign commit_seq_num = wb_q.val ? wb_q.seq_num : '0;
  assign rf_wen         = wb_q.val & wb_q.wen & (wb_q.waddr != WB_ZERO_REG);
  assign rf_waddr       = rf_wen ? wb_q.waddr : '0;
  assign rf_wdata       = rf_wen ? wb_q.wdata : '0;
  assign retire_count   = retire_q;

endmodule

// File: doc/writeback_rr_l2.md
Name: writeback_rr_l2

Overview:
- Writeback stage directly downstream of the L1 execute units (ALU, multiplier, …); consumes their X→W transfers.
- Each cycle, round-robin arbitrates one transfer among p_num_pipes execute pipes.
- Registers the winner for one cycle, then drives the register-file write port and a commit notification (pc, seq_num) to the completion/scoreboard logic.
- Keeps a free-running retired-instruction counter for performance tracing.

Parameters:
- p_num_pipes, 3, number of upstream execute pipes (≥1).
- p_seq_num_bits, 5, width of instruction sequence number.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- X_val  in  p_num_pipes  per-pipe transfer valid.
- X_rdy  out  p_num_pipes  per-pipe ready; one-hot grant or all zero.
- X_pc  in  p_num_pipes×32  per-pipe instruction PC.
- X_seq_num  in  p_num_pipes×p_seq_num_bits  per-pipe sequence number.
- X_waddr  in  p_num_pipes×5  per-pipe destination register.
- X_wdata  in  p_num_pipes×32  per-pipe result.
- X_wen  in  p_num_pipes  per-pipe write enable.
- rf_wen  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.
- commit_val  out  1  one instruction completes this cycle.
- commit_pc  out  32  PC of the completing instruction.
- commit_seq_num  out  p_seq_num_bits  sequence number of the completing instruction.
- retire_count  out  32  number of instructions committed since reset.

Behaviour:
- Clocking: one clock. Reset is asynchronous and active-high; all state clears immediately on rst assertion, independent of clk.
- Grant (combinational):
  - Scan pipes starting at the priority pointer ptr and wrap modulo p_num_pipes.
  - The first pipe with X_val=1 wins; X_rdy[win]=1 and all other X_rdy bits are 0.
  - If no pipe is valid, X_rdy is all 0.
  - X_rdy depends only on X_val and ptr, never on the downstream outputs. There is no backpressure from the register file, so this stage never stalls.
- Transfer: pipe i transfers when X_val[i] & X_rdy[i]. At most one transfer occurs per cycle.
- Pointer update:
  - On a transfer from pipe i, ptr ← (i+1) mod p_num_pipes.
  - With no transfer, ptr holds.
  - The wrap from p_num_pipes−1 goes to 0.
- Writeback register:
  - On a transfer, capture {val=1, pc, seq_num, waddr, wdata, wen} from the winning pipe.
  - Otherwise val ← 0. Payload fields may hold their old values but must be masked at the outputs.
- Outputs, driven from the register (latency exactly 1 cycle from transfer):
  - commit_val = val.
  - commit_pc and commit_seq_num = registered fields when val=1, else 0.
  - rf_wen = val & wen & (waddr≠0). Writes to x0 are suppressed, but the instruction still commits.
  - rf_waddr and rf_wdata = registered fields when rf_wen=1, else 0.
- Retire counter: increments by 1 on every cycle with commit_val=1 and wraps 2^32−1 → 0.
- Reset values: ptr=0, val=0, and all outputs 0 (rf_wen, rf_waddr, rf_wdata, commit_val, commit_pc, commit_seq_num, retire_count).
- Reset mid-operation:
  - A pending registered transaction is dropped (no commit, no RF write).
  - A transfer handshaken in the same cycle rst asserts is lost; upstream must also be in reset.
- Throughput: one commit per cycle sustained when any pipe is valid every cycle. Back-to-back transfers from the same pipe are legal only when it is the sole valid pipe.
- p_num_pipes=1: the pointer is constant 0 and X_rdy = X_val.

Decomposition:
- Shared package WbPkg:
  - packed struct wb_entry {val, pc[31:0], seq_num, waddr[4:0], wdata[31:0], wen}, parameterised via p_seq_num_bits or instantiated locally as a typedef.
  - Constant WB_ZERO_REG = 5'd0.
- One sub-module: rr_arbiter, parameterised by p_num_pipes.
  - Inputs: req vector and xfer strobe.
  - Outputs: one-hot grant and the grant index.
  - Owns the ptr register and its async reset.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle with a valid registered entry → commit_val, rf_wen and retire_count read 0 immediately; the entry never commits.
2. Single pipe: pipe1 sends pc=0x200, seq=3, waddr=5, wdata=0xDEADBEEF, wen=1 at cycle t → X_rdy=3'b010 at t; at t+1 rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF, commit_val=1, commit_seq_num=3; retire_count=1 at t+2.
3. Round robin: all three pipes valid continuously from reset → grant order 0,1,2,0,1,2; one commit per cycle; retire_count=6 after six commits.
4. Pointer skip and wrap: ptr=2, only pipe0 and pipe1 valid → pipe0 wins, ptr becomes 1; next cycle pipe1 wins, ptr becomes 2.
5. x0 and no-write: waddr=0 with wen=1 → rf_wen=0, commit_val=1. A wen=0 instruction with waddr=7 → rf_wen=0, rf_waddr=0, commit_val=1, and retire_count increments.
6. Counter wrap: force retire_count to 0xFFFFFFFF, then commit once → retire_count=0.
